// File: rtl/player_floor_collide_if.sv
// Frame-tick controls, floor inputs from floor_gen and the player outputs of player_floor_collide.
// The master drives ticks, buttons and floors; the slave is the collision stage.
interface player_floor_collide_if;
    logic        tick;
    logic        btn_left;
    logic        btn_right;
    logic [79:0] floor_x_bus;
    logic [79:0] floor_y_bus;
    logic [7:0]  floor_en;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [1:0]  state;
    logic [2:0]  on_floor_idx;
    logic        hit_ceiling;
    logic        game_over;

    modport master (
        output tick, btn_left, btn_right, floor_x_bus, floor_y_bus, floor_en,
        input  player_x, player_y, state, on_floor_idx, hit_ceiling, game_over
    );

    modport slave (
        input  tick, btn_left, btn_right, floor_x_bus, floor_y_bus, floor_en,
        output player_x, player_y, state, on_floor_idx, hit_ceiling, game_over
    );
endinterface

// File: rtl/player_floor_collide.sv
// Per-frame player motion: horizontal buttons, gravity with a capped fall speed,
// landing on and riding floors, ceiling detection and death at the screen bottom.
module player_floor_collide #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PLAYER_SIZE = 20,
    parameter int unsigned FLOOR_HALF  = 50,
    parameter int unsigned CEIL_Y      = 10,
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned MAX_FALL    = 8
) (
    input logic                  clk,
    input logic                  rst,
    player_floor_collide_if.slave bus
);

    typedef enum logic [1:0] {
        StFall  = 2'd0,
        StStand = 2'd1,
        StDead  = 2'd2
    } state_e;

    // 11-bit copies so every sum and compare has headroom over the 10-bit coordinates
    localparam logic [10:0] ScrH  = 11'(SCREEN_H);
    localparam logic [10:0] MaxPx = 11'(SCREEN_W - PLAYER_SIZE);
    localparam logic [10:0] Size  = 11'(PLAYER_SIZE);
    localparam logic [10:0] Half  = 11'(FLOOR_HALF);
    localparam logic [10:0] Ceil  = 11'(CEIL_Y);
    localparam logic [10:0] Step  = 11'(STEP_X);
    localparam logic [3:0]  MaxVy = 4'(MAX_FALL);

    logic [9:0] px_q, py_q;
    logic [3:0] vy_q;
    state_e     state_q;
    logic [2:0] idx_q;
    logic       hit_q, over_q;

    logic [10:0] fx [8];
    logic [10:0] fy [8];
    logic [7:0]  ov;
    logic [10:0] px_w, py_w, px_mv;
    logic [3:0]  vy_n;
    logic [10:0] b, b_n;
    logic        land_hit;
    logic [2:0]  land_idx;
    logic [10:0] fy_k;

    state_e      state_d;
    logic [10:0] py_d;
    logic [3:0]  vy_d;
    logic [2:0]  idx_d;

    assign px_w = {1'b0, px_q};
    assign py_w = {1'b0, py_q};

    always_comb begin
        px_mv = px_w;
        if (bus.btn_left && !bus.btn_right) begin
            px_mv = (px_w >= Step) ? px_w - Step : 11'd0;
        end else if (bus.btn_right && !bus.btn_left) begin
            px_mv = (px_w + Step > MaxPx) ? MaxPx : px_w + Step;
        end
    end

    // Overlap uses the post-move x; a floor left edge below zero is clamped to zero
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            fx[i] = {1'b0, bus.floor_x_bus[i*10 +: 10]};
            fy[i] = {1'b0, bus.floor_y_bus[i*10 +: 10]};
            ov[i] = bus.floor_en[i] &&
                    (px_mv + Size > ((fx[i] < Half) ? 11'd0 : fx[i] - Half)) &&
                    (px_mv < fx[i] + Half);
        end
    end

    assign vy_n = (vy_q >= MaxVy) ? MaxVy : vy_q + 4'd1;
    assign b    = py_w + Size;
    assign b_n  = b + {7'd0, vy_n};
    assign fy_k = fy[idx_q];

    // Scan from the top index down so the lowest qualifying floor is left standing
    always_comb begin
        land_hit = 1'b0;
        land_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ov[i] && (b <= fy[i]) && (b_n >= fy[i])) begin
                land_hit = 1'b1;
                land_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        py_d    = py_w;
        vy_d    = vy_q;
        idx_d   = idx_q;
        case (state_q)
            StFall: begin
                if (land_hit) begin
                    py_d    = fy[land_idx] - Size;
                    vy_d    = 4'd0;
                    idx_d   = land_idx;
                    state_d = StStand;
                end else if (b_n >= ScrH) begin
                    py_d    = ScrH - Size;
                    state_d = StDead;
                end else begin
                    py_d = b_n - Size;
                    vy_d = vy_n;
                end
            end
            StStand: begin
                if (!ov[idx_q] || (fy_k < Size)) begin
                    vy_d    = 4'd0;
                    state_d = StFall;
                end else if (fy_k >= ScrH) begin
                    state_d = StDead;
                end else begin
                    py_d = fy_k - Size;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q    <= 10'd310;
            py_q    <= 10'd100;
            vy_q    <= 4'd0;
            state_q <= StFall;
            idx_q   <= 3'd0;
            hit_q   <= 1'b0;
            over_q  <= 1'b0;
        end else if (bus.tick && (state_q != StDead)) begin
            px_q    <= px_mv[9:0];
            py_q    <= py_d[9:0];
            vy_q    <= vy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= (state_d != StDead) && (py_d <= Ceil);
            over_q  <= (state_d == StDead);
        end
    end

    // Top bits are always zero once clamped; kept only for width-safe arithmetic
    logic unused_msb;
    assign unused_msb = px_mv[10] ^ py_d[10];

    assign bus.player_x     = px_q;
    assign bus.player_y     = py_q;
    assign bus.state        = state_q;
    assign bus.on_floor_idx = idx_q;
    assign bus.hit_ceiling  = hit_q;
    assign bus.game_over    = over_q;

endmodule

// File: tb/tb_player_floor_collide.sv
// Self-checking bench for player_floor_collide: a behavioural model pushes expected
// snapshots to a scoreboard on every tick; each scenario pops and compares them.
module tb_player_floor_collide;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic [1:0] st;
        logic [2:0] idx;
        logic       hit;
        logic       go;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] tfx [8];
    logic [9:0] tfy [8];
    logic [7:0] en;

    player_floor_collide_if bus ();

    player_floor_collide dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.floor_en = en;
        for (int i = 0; i < 8; i++) begin
            bus.floor_x_bus[i*10 +: 10] = tfx[i];
            bus.floor_y_bus[i*10 +: 10] = tfy[i];
        end
    end

    snap_t cur;
    assign cur = {bus.player_x, bus.player_y, bus.state, bus.on_floor_idx,
                  bus.hit_ceiling, bus.game_over};

    snap_t sb[$];
    snap_t want;
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0=FALL 1=STAND 2=DEAD
    int m_px, m_py, m_vy, m_st, m_idx, m_hit, m_go;

    function automatic bit m_ov(int i, int px);
        int fxi, lo;
        fxi = int'(tfx[i]);
        lo  = (fxi < 50) ? 0 : fxi - 50;
        return en[i] && (px + 20 > lo) && (px < fxi + 50);
    endfunction

    function automatic snap_t m_snap();
        return {10'(m_px), 10'(m_py), 2'(m_st), 3'(m_idx), 1'(m_hit), 1'(m_go)};
    endfunction

    task automatic model_reset();
        m_px = 310; m_py = 100; m_vy = 0; m_st = 0; m_idx = 0; m_hit = 0; m_go = 0;
    endtask

    task automatic model_tick();
        int npx, vyn, b, bn, land, fyk;
        if (m_st == 2) return;
        npx = m_px;
        if (bus.btn_left && !bus.btn_right) npx = (m_px < 4) ? 0 : m_px - 4;
        else if (bus.btn_right && !bus.btn_left) npx = (m_px + 4 > 620) ? 620 : m_px + 4;
        if (m_st == 0) begin
            vyn  = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            b    = m_py + 20;
            bn   = b + vyn;
            land = -1;
            for (int i = 0; i < 8; i++)
                if (land < 0 && m_ov(i, npx) && b <= int'(tfy[i]) && bn >= int'(tfy[i]))
                    land = i;
            if (land >= 0) begin
                m_py = int'(tfy[land]) - 20; m_vy = 0; m_idx = land; m_st = 1;
            end else if (bn >= 480) begin
                m_st = 2; m_py = 460;
            end else begin
                m_py = bn - 20; m_vy = vyn;
            end
        end else begin
            fyk = int'(tfy[m_idx]);
            if (!m_ov(m_idx, npx) || fyk < 20) begin
                m_st = 0; m_vy = 0;
            end else if (fyk >= 480) begin
                m_st = 2;
            end else begin
                m_py = fyk - 20;
            end
        end
        m_px  = npx;
        m_go  = (m_st == 2);
        m_hit = (m_st != 2 && m_py <= 10);
    endtask

    task automatic step();
        bus.tick = 1'b1;
        model_tick();
        sb.push_back(m_snap());
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic do_reset(input bit with_tick);
        rst      = 1'b1;
        bus.tick = with_tick;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.tick = 1'b0;
        model_reset();
        sb.push_back({10'd310, 10'd100, 2'd0, 3'd0, 1'b0, 1'b0});
    endtask

    task automatic clear_floors();
        en = 8'd0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tfx[i] = 10'd0;
            tfy[i] = 10'd0;
        end
    endtask

    // Falls onto floor0 at (320,200), checking every tick, bounded
    task automatic land_floor0(input string name);
        clear_floors();
        en = 8'd1; tfx[0] = 10'd320; tfy[0] = 10'd200;
        do_reset(1'b0);
        want = sb.pop_front();
        n_checks++;
        if (cur !== want) $display("FAIL %s_reset: got %p want %p", name, cur, want);
        else n_pass++;
        for (int k = 0; k < 40 && cur.st != 2'd1; k++) begin
            step();
            want = sb.pop_front();
            n_checks++;
            if (cur !== want) $display("FAIL %s_fall[%0d]: got %p want %p", name, k, cur, want);
            else n_pass++;
        end
        n_checks++;
        if (cur.st !== 2'd1 || cur.py !== 10'd180 || cur.idx !== 3'd0)
            $display("FAIL %s_landed: got st=%0d py=%0d idx=%0d want st=1 py=180 idx=0",
                     name, cur.st, cur.py, cur.idx);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_floors();
        do_reset(1'b0);
        want = sb.pop_front();
        n_checks++;
        if (cur !== want) $display("FAIL reset_values: got %p want %p", cur, want);
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (cur !== want) $display("FAIL reset_hold: got %p want %p", cur, want);
        else n_pass++;
    endtask

    task automatic test_free_fall();
        int first_py [4];
        first_py = '{101, 103, 106, 110};
        clear_floors();
        do_reset(1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 100 && !cur.go; k++) begin
            step();
            want = sb.pop_front();
            n_checks++;
            if (cur !== want) $display("FAIL fall[%0d]: got %p want %p", k, cur, want);
            else n_pass++;
            if (k < 4) begin
                n_checks++;
                if (cur.py !== 10'(first_py[k]))
                    $display("FAIL fall_py[%0d]: got %0d want %0d", k, cur.py, first_py[k]);
                else n_pass++;
            end
        end
        n_checks++;
        if (cur.go !== 1'b1 || cur.st !== 2'd2 || cur.py !== 10'd460)
            $display("FAIL fall_dead: got go=%0d st=%0d py=%0d want go=1 st=2 py=460",
                     cur.go, cur.st, cur.py);
        else n_pass++;
        // DEAD ignores buttons and floors
        bus.btn_left = 1'b1; en = 8'hff;
        repeat (3) step();
        repeat (3) begin
            want = sb.pop_front();
            n_checks++;
            if (cur !== want) $display("FAIL dead_absorb: got %p want %p", cur, want);
            else n_pass++;
        end
    endtask

    task automatic test_tracking();
        int ys [2];
        ys = '{201, 205};
        land_floor0("track");
        for (int k = 0; k < 2; k++) begin
            tfy[0] = 10'(ys[k]);
            step();
            want = sb.pop_front();
            n_checks++;
            if (cur !== want || cur.py !== 10'(ys[k] - 20))
                $display("FAIL track_y[%0d]: got %p want %p", k, cur, want);
            else n_pass++;
        end
        bus.btn_right = 1'b1;
        for (int k = 0; k < 30 && cur.st == 2'd1; k++) begin
            step();
            want = sb.pop_front();
            n_checks++;
            if (cur !== want) $display("FAIL walk[%0d]: got %p want %p", k, cur, want);
            else n_pass++;
        end
        n_checks++;
        if (cur.st !== 2'd0 || cur.px !== 10'd370)
            $display("FAIL walk_off: got st=%0d px=%0d want st=0 px=370", cur.st, cur.px);
        else n_pass++;
        bus.btn_right = 1'b0;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.py !== 10'd186)
            $display("FAIL walk_vy0: got %p want %p", cur, want);
        else n_pass++;
    endtask

    task automatic test_priority();
        clear_floors();
        en = 8'b0010_0100;
        tfx[2] = 10'd300; tfy[2] = 10'd121;
        tfx[5] = 10'd340; tfy[5] = 10'd121;
        do_reset(1'b0);
        void'(sb.pop_front());
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.idx !== 3'd2 || cur.st !== 2'd1)
            $display("FAIL prio_idx: got %p want %p", cur, want);
        else n_pass++;
        tfy[2] = 10'd480;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.st !== 2'd2 || cur.go !== 1'b1)
            $display("FAIL prio_dead480: got %p want %p", cur, want);
        else n_pass++;
    endtask

    task automatic test_ceiling();
        land_floor0("ceil");
        tfy[0] = 10'd30;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.py !== 10'd10 || cur.hit !== 1'b1)
            $display("FAIL ceil_on: got %p want %p", cur, want);
        else n_pass++;
        tfy[0] = 10'd31;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.py !== 10'd11 || cur.hit !== 1'b0)
            $display("FAIL ceil_off: got %p want %p", cur, want);
        else n_pass++;
    endtask

    task automatic test_clamps();
        land_floor0("clamp");
        bus.btn_left = 1'b1;
        for (int k = 0; k < 100 && cur.px > 10'd2; k++) begin
            tfx[0] = tfx[0] - 10'd4;
            step();
            want = sb.pop_front();
            n_checks++;
            if (cur !== want) $display("FAIL carry_left[%0d]: got %p want %p", k, cur, want);
            else n_pass++;
        end
        tfx[0] = tfx[0] - 10'd4;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.px !== 10'd0 || cur.st !== 2'd1)
            $display("FAIL clamp_left: got %p want %p", cur, want);
        else n_pass++;
        bus.btn_right = 1'b1;
        step();
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.px !== 10'd0)
            $display("FAIL both_buttons: got %p want %p", cur, want);
        else n_pass++;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    endtask

    task automatic test_reset_mid();
        land_floor0("rstmid");
        do_reset(1'b1);
        want = sb.pop_front();
        n_checks++;
        if (cur !== want) $display("FAIL rst_stand: got %p want %p", cur, want);
        else n_pass++;
        en = 8'd0;
        for (int k = 0; k < 100 && !cur.go; k++) begin
            step();
            void'(sb.pop_front());
        end
        n_checks++;
        if (cur.go !== 1'b1) $display("FAIL rst_reach_dead: got go=%0d want 1", cur.go);
        else n_pass++;
        do_reset(1'b0);
        want = sb.pop_front();
        n_checks++;
        if (cur !== want || cur.go !== 1'b0 || cur.st !== 2'd0)
            $display("FAIL rst_dead: got %p want %p", cur, want);
        else n_pass++;
    endtask

    initial begin
        bus.tick = 1'b0;
        clear_floors();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_free_fall();
        test_tracking();
        test_priority();
        test_ceiling();
        test_clamps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
